i2c_trx: RTL and testbench

//  I2C target (slave) transceiver with an 8 x 8-bit register file, driven from the 50 MHz system clock.

---
 rtl/i2c_trx.sv | 204 ++++++++++++++++++++
 tb/tb_i2c_trx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_trx.sv
// i2c_trx: I2C target with an 8 x 8-bit register file, pads oversampled on clk_50M.
// Defining I2C_GLITCH_FILTER_EN adds a GLT_LEN-cycle spike filter after each pad synchronizer.
module i2c_trx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         GLT_LEN    = 4,
    parameter logic [7:0] REG_INIT   = 8'h00
) (
    input  logic clk_50M,
    input  logic rst_n,
    inout  wire  Pad_SDA,
    inout  wire  Pad_SCL
);

`ifdef I2C_GLITCH_FILTER_EN
    localparam bit FLT_ON = 1'b1;
`else
    localparam bit FLT_ON = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_t;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_flt, sda_flt;
    logic       scl_d, sda_d;
    logic       scl_rise, scl_fall, start_det, stop_det;

    state_t     state, state_nxt;
    logic       sda_oe, oe_nxt;
    logic [3:0] bit_cnt, cnt_nxt;
    logic [7:0] shift, shift_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic       wr_en;
    logic [7:0] rx_byte, rd_byte;
    logic [7:0] regs [8];

    // Open-drain: only ever pull low; SCL is never driven (no clock stretching).
    assign Pad_SDA = sda_oe ? 1'b0 : 1'bz;
    assign Pad_SCL = 1'bz;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], Pad_SCL};
            sda_sync <= {sda_sync[0], Pad_SDA};
        end
    end

    generate
        if (FLT_ON && GLT_LEN > 0) begin : g_flt
            localparam int CW = $clog2(GLT_LEN + 1);
            logic [CW-1:0] scl_cnt, sda_cnt;
            // A new level must persist GLT_LEN consecutive cycles before it is accepted.
            always_ff @(posedge clk_50M or negedge rst_n) begin
                if (!rst_n) begin
                    scl_cnt <= '0;
                    sda_cnt <= '0;
                    scl_flt <= 1'b1;
                    sda_flt <= 1'b1;
                end else begin
                    if (scl_sync[1] == scl_flt) scl_cnt <= '0;
                    else if (scl_cnt == CW'(GLT_LEN - 1)) begin
                        scl_flt <= scl_sync[1];
                        scl_cnt <= '0;
                    end else scl_cnt <= scl_cnt + CW'(1);
                    if (sda_sync[1] == sda_flt) sda_cnt <= '0;
                    else if (sda_cnt == CW'(GLT_LEN - 1)) begin
                        sda_flt <= sda_sync[1];
                        sda_cnt <= '0;
                    end else sda_cnt <= sda_cnt + CW'(1);
                end
            end
        end else begin : g_noflt
            assign scl_flt = scl_sync[1];
            assign sda_flt = sda_sync[1];
        end
    endgenerate

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_flt;
            sda_d <= sda_flt;
        end
    end

    assign scl_rise  = scl_flt & ~scl_d;
    assign scl_fall  = ~scl_flt & scl_d;
    assign start_det = scl_flt & scl_d & sda_d & ~sda_flt;
    assign stop_det  = scl_flt & scl_d & ~sda_d & sda_flt;
    assign rx_byte   = {shift[6:0], sda_flt};
    assign rd_byte   = regs[ptr];

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
            shift   <= '0;
            ptr     <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= REG_INIT;
        end else begin
            state   <= state_nxt;
            sda_oe  <= oe_nxt;
            bit_cnt <= cnt_nxt;
            shift   <= shift_nxt;
            ptr     <= ptr_nxt;
            if (wr_en) regs[ptr] <= rx_byte;
        end
    end

    // bit_cnt == 8 marks a completed byte waiting for the falling edge that starts its ACK slot.
    always_comb begin
        state_nxt = state;
        oe_nxt    = sda_oe;
        cnt_nxt   = bit_cnt;
        shift_nxt = shift;
        ptr_nxt   = ptr;
        wr_en     = 1'b0;
        if (start_det) begin
            state_nxt = DEV_ADDR;
            oe_nxt    = 1'b0;
            cnt_nxt   = '0;
            shift_nxt = '0;
        end else if (stop_det) begin
            state_nxt = IDLE;
            oe_nxt    = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                DEV_ADDR, REG_ADDR, WR_DATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_nxt = rx_byte;
                        cnt_nxt   = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (state == DEV_ADDR && rx_byte[7:1] != SLAVE_ADDR) state_nxt = IDLE;
                            if (state == REG_ADDR) ptr_nxt = rx_byte[2:0];
                            if (state == WR_DATA) wr_en = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        oe_nxt = 1'b1;
                        if (state == DEV_ADDR)      state_nxt = DEV_ACK;
                        else if (state == REG_ADDR) state_nxt = REG_ACK;
                        else                        state_nxt = WR_ACK;
                    end
                end
                DEV_ACK: begin
                    if (scl_fall) begin
                        cnt_nxt = '0;
                        if (shift[0]) begin
                            state_nxt = RD_DATA;
                            shift_nxt = rd_byte;
                            oe_nxt    = ~rd_byte[7];
                        end else begin
                            state_nxt = REG_ADDR;
                            oe_nxt    = 1'b0;
                        end
                    end
                end
                REG_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        state_nxt = WR_DATA;
                        oe_nxt    = 1'b0;
                        cnt_nxt   = '0;
                        if (state == WR_ACK) ptr_nxt = ptr + 3'd1;
                    end
                end
                RD_DATA: begin
                    if (scl_rise && bit_cnt < 4'd8) cnt_nxt = bit_cnt + 4'd1;
                    else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_nxt = RD_ACK;
                            oe_nxt    = 1'b0;
                        end else begin
                            shift_nxt = {shift[6:0], 1'b0};
                            oe_nxt    = ~shift[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_flt) state_nxt = IDLE;
                        else begin
                            ptr_nxt = ptr + 3'd1;
                            cnt_nxt = 4'd9;
                        end
                    end else if (scl_fall && bit_cnt == 4'd9) begin
                        state_nxt = RD_DATA;
                        cnt_nxt   = '0;
                        shift_nxt = rd_byte;
                        oe_nxt    = ~rd_byte[7];
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_trx.sv
// tb_i2c_trx: bus-master driven bench for i2c_trx, checked against an array model of the register file.
// Define I2C_GLITCH_FILTER_EN for both bench and design to run the SCL spike case.
module tb_i2c_trx;

    localparam int Q = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic m_sda = 1'b1;
    logic m_scl = 1'b1;
    wire  sda_bus;
    wire  scl_bus;

    assign sda_bus = m_sda ? 1'bz : 1'b0;
    assign scl_bus = m_scl ? 1'bz : 1'b0;
    pullup (sda_bus);
    pullup (scl_bus);

    always #10 clk = ~clk;

    i2c_trx dut (
        .clk_50M (clk),
        .rst_n   (rst_n),
        .Pad_SDA (sda_bus),
        .Pad_SCL (scl_bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         dut_low_cnt = 0;
    int         spike_bit = -1;
    logic [7:0] model_regs [8];
    logic [7:0] wr_q [$];
    logic [7:0] exp_q [$];

    // Counts cycles where SDA is low although the master is releasing it.
    always @(negedge clk) if (m_sda && sda_bus === 1'b0) dut_low_cnt <= dut_low_cnt + 1;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic clock_bit(input logic b, input logic spike, output logic s);
        m_sda = b;
        if (spike) begin
            repeat (3) @(negedge clk);
            m_scl = 1'b1;
            repeat (2) @(negedge clk);
            m_scl = 1'b0;
            repeat (Q - 5) @(negedge clk);
        end else wait_q();
        m_scl = 1'b1; wait_q();
        s = sda_bus;  wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], (i == spike_bit), s);
        clock_bit(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        clock_bit(nack, 1'b0, s);
    endtask

    task automatic write_txn(input logic [7:0] addr);
        logic       ack;
        logic [2:0] p;
        i2c_start();
        send_byte(8'hA0, ack); check_eq("wr_dev_ack", {7'b0, ack}, 8'h00);
        send_byte(addr, ack);  check_eq("wr_reg_ack", {7'b0, ack}, 8'h00);
        p = addr[2:0];
        foreach (wr_q[i]) begin
            send_byte(wr_q[i], ack);
            check_eq($sformatf("wr_data_ack r%0d", p), {7'b0, ack}, 8'h00);
            model_regs[p] = wr_q[i];
            p = p + 3'd1;
        end
        i2c_stop();
    endtask

    task automatic read_txn(input logic [7:0] addr, input int n);
        logic       ack;
        logic [7:0] d;
        logic [2:0] p;
        p = addr[2:0];
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_regs[p]);
            p = p + 3'd1;
        end
        i2c_start();
        send_byte(8'hA0, ack); check_eq("rd_dev_ack", {7'b0, ack}, 8'h00);
        send_byte(addr, ack);  check_eq("rd_reg_ack", {7'b0, ack}, 8'h00);
        i2c_start();
        send_byte(8'hA1, ack); check_eq("rd_devr_ack", {7'b0, ack}, 8'h00);
        p = addr[2:0];
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            check_eq($sformatf("rd_data r%0d", p), d, exp_q.pop_front());
            p = p + 3'd1;
        end
        i2c_stop();
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] addr;
        int         n;
        int         base;

        for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_sda_released", {7'b0, sda_bus}, 8'h01);

        for (int i = 0; i < 8; i++) read_txn(8'(i), 1);

        for (int i = 0; i < 8; i++) begin
            wr_q.delete(); wr_q.push_back(8'(i));
            write_txn(8'(i));
        end
        read_txn(8'h00, 8);

        for (int i = 0; i < 8; i++) begin
            wr_q.delete(); wr_q.push_back(8'(i + 8));
            write_txn(8'(i));
        end
        read_txn(8'h00, 8);

        base = dut_low_cnt;
        i2c_start(); i2c_stop();
        i2c_start(); i2c_stop();
        check_eq("bare_start_stop_drive", {7'b0, (dut_low_cnt != base)}, 8'h00);
        read_txn(8'h05, 1);

        base = dut_low_cnt;
        i2c_start();
        send_byte(8'hA2, ack); check_eq("wrong_dev_nack", {7'b0, ack}, 8'h01);
        send_byte(8'h03, ack);
        send_byte(8'h55, ack);
        i2c_stop();
        check_eq("wrong_dev_drive", {7'b0, (dut_low_cnt != base)}, 8'h00);
        read_txn(8'h03, 1);

`ifdef I2C_GLITCH_FILTER_EN
        spike_bit = 3;
        wr_q.delete(); wr_q.push_back(8'hA5);
        write_txn(8'h04);
        spike_bit = -1;
        read_txn(8'h04, 1);
`endif

        read_txn(8'hFE, 4);

        for (int k = 0; k < 12; k++) begin
            addr = 8'($urandom_range(0, 255));
            n    = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                wr_q.delete();
                for (int j = 0; j < n; j++) wr_q.push_back(8'($urandom));
                write_txn(addr);
            end else read_txn(addr, n);
        end
        read_txn(8'h00, 8);

        // Reset while the target is holding its data ACK low.
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h02, ack);
        for (int i = 7; i >= 0; i--) clock_bit(1'b0, 1'b0, s);
        m_sda = 1'b1;
        wait_q();
        check_eq("ack_low_before_rst", {7'b0, sda_bus}, 8'h00);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("sda_released_in_rst", {7'b0, sda_bus}, 8'h01);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        i2c_stop();
        for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
        read_txn(8'h00, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
